// File: rtl/cmp_relation_filter_if.sv
// Bus between the magnitude comparator and the relation filter.
// The master drives the comparator triplet and controls; the slave returns the filtered relation.
interface cmp_relation_filter_if #(
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             eq_in;
  logic             agt_in;
  logic             bgt_in;
  logic [1:0]       rel_out;
  logic             rel_valid;
  logic             rel_change;
  logic             err_pulse;
  logic [CNT_W-1:0] change_count;

  modport master (
    output clear, in_valid, eq_in, agt_in, bgt_in,
    input  rel_out, rel_valid, rel_change, err_pulse, change_count
  );

  modport slave (
    input  clear, in_valid, eq_in, agt_in, bgt_in,
    output rel_out, rel_valid, rel_change, err_pulse, change_count
  );
endinterface

// File: rtl/cmp_relation_filter.sv
// Debounces the comparator's one-hot relation: a relation is accepted only after
// STABLE_CNT consecutive identical legal samples, with change/error pulses and a change counter.
module cmp_relation_filter #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  cmp_relation_filter_if.slave bus
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [1:0] REL_NONE   = 2'b00;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CNT);

  state_t           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [7:0]       run_cnt_q, run_cnt_d;
  logic [1:0]       rel_out_q, rel_out_d;
  logic             rel_valid_q, rel_valid_d;
  logic             rel_change_q, rel_change_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] change_count_q, change_count_d;

  logic             legal;
  logic [1:0]       code;

  // Exactly one input high: odd parity excludes 0 and 2, the AND excludes 3.
  assign legal = (bus.eq_in ^ bus.agt_in ^ bus.bgt_in) &
                 ~(bus.eq_in & bus.agt_in & bus.bgt_in);

  always_comb begin
    code = 2'b00;
    if (bus.eq_in)       code = 2'b01;
    else if (bus.agt_in) code = 2'b10;
    else if (bus.bgt_in) code = 2'b11;
  end

  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    run_cnt_d      = run_cnt_q;
    rel_out_d      = rel_out_q;
    rel_valid_d    = rel_valid_q;
    rel_change_d   = 1'b0;
    err_pulse_d    = 1'b0;
    change_count_d = change_count_q;

    if (bus.clear) begin
      state_d        = UNLOCKED;
      cand_d         = REL_NONE;
      run_cnt_d      = '0;
      rel_out_d      = REL_NONE;
      rel_valid_d    = 1'b0;
      change_count_d = '0;
    end else if (bus.in_valid) begin
      if (!legal) begin
        err_pulse_d = 1'b1;
        cand_d      = REL_NONE;
        run_cnt_d   = '0;
      end else begin
        if (code == cand_q) begin
          run_cnt_d = (run_cnt_q >= STABLE_MAX) ? STABLE_MAX : run_cnt_q + 8'd1;
        end else begin
          cand_d    = code;
          run_cnt_d = 8'd1;
        end
        // Saturated runs matching the held relation must not re-trigger acceptance.
        if (run_cnt_d == STABLE_MAX && (state_q == UNLOCKED || cand_d != rel_out_q)) begin
          state_d        = LOCKED;
          rel_out_d      = cand_d;
          rel_valid_d    = 1'b1;
          rel_change_d   = 1'b1;
          change_count_d = change_count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= UNLOCKED;
      cand_q         <= REL_NONE;
      run_cnt_q      <= '0;
      rel_out_q      <= REL_NONE;
      rel_valid_q    <= 1'b0;
      rel_change_q   <= 1'b0;
      err_pulse_q    <= 1'b0;
      change_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      run_cnt_q      <= run_cnt_d;
      rel_out_q      <= rel_out_d;
      rel_valid_q    <= rel_valid_d;
      rel_change_q   <= rel_change_d;
      err_pulse_q    <= err_pulse_d;
      change_count_q <= change_count_d;
    end
  end

  assign bus.rel_out      = rel_out_q;
  assign bus.rel_valid    = rel_valid_q;
  assign bus.rel_change   = rel_change_q;
  assign bus.err_pulse    = err_pulse_q;
  assign bus.change_count = change_count_q;

endmodule

// File: tb/tb_cmp_relation_filter.sv
// Directed bench for cmp_relation_filter: three instances (default, 2-bit counter,
// STABLE_CNT=1) share one stimulus stream; each phase checks the instance it targets.
module tb_cmp_relation_filter;

  logic clk;
  logic rst_n;
  logic clear_in;
  logic valid_in;
  logic eq_drv;
  logic agt_drv;
  logic bgt_drv;

  int check_count;
  int error_count;
  int pulse_sum;

  cmp_relation_filter_if #(.CNT_W(8)) bus_a ();
  cmp_relation_filter_if #(.CNT_W(2)) bus_w ();
  cmp_relation_filter_if #(.CNT_W(8)) bus_s ();

  assign bus_a.clear    = clear_in;
  assign bus_a.in_valid = valid_in;
  assign bus_a.eq_in    = eq_drv;
  assign bus_a.agt_in   = agt_drv;
  assign bus_a.bgt_in   = bgt_drv;
  assign bus_w.clear    = clear_in;
  assign bus_w.in_valid = valid_in;
  assign bus_w.eq_in    = eq_drv;
  assign bus_w.agt_in   = agt_drv;
  assign bus_w.bgt_in   = bgt_drv;
  assign bus_s.clear    = clear_in;
  assign bus_s.in_valid = valid_in;
  assign bus_s.eq_in    = eq_drv;
  assign bus_s.agt_in   = agt_drv;
  assign bus_s.bgt_in   = bgt_drv;

  cmp_relation_filter #(.STABLE_CNT(4), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  cmp_relation_filter #(.STABLE_CNT(4), .CNT_W(2)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
  cmp_relation_filter #(.STABLE_CNT(1), .CNT_W(8)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one sample for a full cycle; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic e, input logic a, input logic b);
    valid_in = v;
    eq_drv   = e;
    agt_drv  = a;
    bgt_drv  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rst_n       = 1'b0;
    clear_in    = 1'b0;
    valid_in    = 1'b0;
    eq_drv      = 1'b0;
    agt_drv     = 1'b0;
    bgt_drv     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_rel_out", 32'(bus_a.rel_out), 32'h0);
    checkOutput("rst_rel_valid", 32'(bus_a.rel_valid), 32'h0);
    checkOutput("rst_rel_change", 32'(bus_a.rel_change), 32'h0);
    checkOutput("rst_err_pulse", 32'(bus_a.err_pulse), 32'h0);
    checkOutput("rst_count", 32'(bus_a.change_count), 32'h0);

    $display("[TB] first EQ lock");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("eq3_rel_valid", 32'(bus_a.rel_valid), 32'h0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("eq4_rel_out", 32'(bus_a.rel_out), 32'h1);
    checkOutput("eq4_rel_valid", 32'(bus_a.rel_valid), 32'h1);
    checkOutput("eq4_rel_change", 32'(bus_a.rel_change), 32'h1);
    checkOutput("eq4_count", 32'(bus_a.change_count), 32'h1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("eq_pulse_one_cycle", 32'(bus_a.rel_change), 32'h0);

    $display("[TB] interrupted AGT run");
    pulse_sum = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0);
      pulse_sum += int'(bus_a.rel_change);
    end
    applyStimulus(1, 0, 0, 1);
    pulse_sum += int'(bus_a.rel_change);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 0);
      pulse_sum += int'(bus_a.rel_change);
    end
    checkOutput("agt7_rel_out", 32'(bus_a.rel_out), 32'h1);
    applyStimulus(1, 0, 1, 0);
    pulse_sum += int'(bus_a.rel_change);
    checkOutput("agt_rel_out", 32'(bus_a.rel_out), 32'h2);
    checkOutput("agt_count", 32'(bus_a.change_count), 32'h2);
    checkOutput("agt_pulse_total", 32'(pulse_sum), 32'h1);

    $display("[TB] illegal samples");
    applyStimulus(1, 1, 1, 0);
    checkOutput("ill2_err", 32'(bus_a.err_pulse), 32'h1);
    checkOutput("ill2_change", 32'(bus_a.rel_change), 32'h0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("ill0_err", 32'(bus_a.err_pulse), 32'h1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ill_err_cleared", 32'(bus_a.err_pulse), 32'h0);
    checkOutput("ill_rel_out", 32'(bus_a.rel_out), 32'h2);
    checkOutput("ill_rel_valid", 32'(bus_a.rel_valid), 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
    checkOutput("bgt3_rel_out", 32'(bus_a.rel_out), 32'h2);
    applyStimulus(1, 0, 0, 1);
    checkOutput("bgt4_rel_out", 32'(bus_a.rel_out), 32'h3);
    checkOutput("bgt4_count", 32'(bus_a.change_count), 32'h3);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("hold_no_pulse", 32'(bus_a.rel_change), 32'h0);
    checkOutput("hold_count", 32'(bus_a.change_count), 32'h3);

    $display("[TB] gapped samples");
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1);
      for (int j = 0; j < 5; j++) applyStimulus(0, 0, 0, 0);
    end
    checkOutput("gap3_rel_valid", 32'(bus_a.rel_valid), 32'h0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("gap4_rel_out", 32'(bus_a.rel_out), 32'h3);
    checkOutput("gap4_count", 32'(bus_a.change_count), 32'h1);

    $display("[TB] counter wrap");
    pulseReset();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i % 2 == 0) applyStimulus(1, 1, 0, 0);
        else            applyStimulus(1, 0, 1, 0);
      end
      if (i == 3) checkOutput("wrap4_count", 32'(bus_w.change_count), 32'h0);
    end
    checkOutput("wrap5_count", 32'(bus_w.change_count), 32'h1);
    checkOutput("wrap5_rel_out", 32'(bus_w.rel_out), 32'h1);
    checkOutput("nowrap5_count", 32'(bus_a.change_count), 32'h5);

    $display("[TB] clear with completing sample");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
    clear_in = 1'b1;
    applyStimulus(1, 0, 0, 1);
    clear_in = 1'b0;
    checkOutput("clr_rel_out", 32'(bus_w.rel_out), 32'h0);
    checkOutput("clr_rel_valid", 32'(bus_w.rel_valid), 32'h0);
    checkOutput("clr_rel_change", 32'(bus_w.rel_change), 32'h0);
    checkOutput("clr_count", 32'(bus_w.change_count), 32'h0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("clr_run_restart", 32'(bus_w.rel_valid), 32'h0);

    $display("[TB] STABLE_CNT=1 and async reset");
    pulseReset();
    applyStimulus(1, 1, 0, 0);
    checkOutput("s1_eq_change", 32'(bus_s.rel_change), 32'h1);
    checkOutput("s1_eq_rel", 32'(bus_s.rel_out), 32'h1);
    applyStimulus(1, 0, 1, 0);
    checkOutput("s1_agt_change", 32'(bus_s.rel_change), 32'h1);
    checkOutput("s1_agt_rel", 32'(bus_s.rel_out), 32'h2);
    applyStimulus(1, 0, 1, 0);
    checkOutput("s1_agt2_change", 32'(bus_s.rel_change), 32'h0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("s1_bgt_change", 32'(bus_s.rel_change), 32'h1);
    checkOutput("s1_bgt_rel", 32'(bus_s.rel_out), 32'h3);
    checkOutput("s1_count", 32'(bus_s.change_count), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_rel_out", 32'(bus_s.rel_out), 32'h0);
    checkOutput("arst_rel_valid", 32'(bus_s.rel_valid), 32'h0);
    checkOutput("arst_rel_change", 32'(bus_s.rel_change), 32'h0);
    checkOutput("arst_count", 32'(bus_s.change_count), 32'h0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
